// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 width codes, FSM states and
// timeout counter sizing.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } lsu_state_e;

  // Wide enough to hold the timeout value itself.
  function automatic int unsigned lsu_cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data replication, load lane select with sign/zero
// extension, and misalignment detection. Unlisted funct3 encodings behave as a word access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        is_unsigned;

  assign is_unsigned = funct3_i[2];

  always_comb begin
    unique case (off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Halfwords only look at off[1] and words ignore the offset, so the lane logic is already
  // forced to alignment; trapping (if any) is decided by the caller from misalign_o.
  always_comb begin
    wstrb_o    = 4'b1111;
    wdata_o    = wdata_i;
    ld_data_o  = rdata_i;
    misalign_o = 1'b0;
    unique case (funct3_i)
      F3_B, F3_BU: begin
        wstrb_o   = 4'b0001 << off_i;
        wdata_o   = {4{wdata_i[7:0]}};
        ld_data_o = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      end
      F3_H, F3_HU: begin
        misalign_o = off_i[0];
        wstrb_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        ld_data_o  = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      end
      default: begin
        misalign_o = (off_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per load or store, with timeout.
// Define MEM_LSU_MISALIGN_TRAP_EN to complete misaligned accesses with misalign=1 and no bus access.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            ld_valid,
  output logic [XLEN-1:0] ld_data,
  output logic            bus_err,
  output logic            misalign,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int unsigned      CntW    = lsu_cnt_width(BUS_TIMEOUT);
  localparam logic [CntW-1:0]  CntLast = CntW'(BUS_TIMEOUT - 1);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]      bus_wstrb_q, bus_wstrb_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic            ld_valid_q, ld_valid_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            bus_err_q, bus_err_d;
  logic            misalign_q, misalign_d;

  logic            start, trap;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata, al_ld_data;
  logic            al_misalign;

  assign start = req_valid & (mem_read | mem_write);

  // Live request fields while idle (store formatting), captured ones while waiting (load extract).
  assign al_f3  = (state_q == StIdle) ? funct3 : f3_q;
  assign al_off = (state_q == StIdle) ? addr[1:0] : off_q;
  assign trap   = TrapEn & al_misalign;

  lsu_align u_align (
    .funct3_i   (al_f3),
    .off_i      (al_off),
    .wdata_i    (wdata),
    .rdata_i    (bus_rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld_data),
    .misalign_o (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = '0;
    bus_err_d   = 1'b0;
    misalign_d  = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = start;
        if (start) begin
          f3_d  = funct3;
          off_d = addr[1:0];
          cnt_d = '0;
          if (trap) begin
            state_d    = StResp;
            ld_valid_d = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d     = StWait;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[XLEN-1:2], 2'b00};
            bus_wstrb_d = mem_write ? al_wstrb : 4'b0000;
            bus_wdata_d = mem_write ? al_wdata : '0;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (bus_ack) begin
          state_d    = StResp;
          bus_req_d  = 1'b0;
          ld_valid_d = 1'b1;
          ld_data_d  = bus_we_q ? '0 : al_ld_data;
        end else if (cnt_q == CntLast) begin
          state_d    = StResp;
          bus_req_d  = 1'b0;
          ld_valid_d = 1'b1;
          bus_err_d  = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign bus_err   = bus_err_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with BUS_TIMEOUT=8; honours MEM_LSU_MISALIGN_TRAP_EN.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, bus_err, misalign, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_lsu #(
    .XLEN        (32),
    .BUS_TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every ld_valid pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("ld_data", ld_data, mon_e.data);
        check_eq("bus_err", 32'(bus_err), 32'(mon_e.err));
        check_eq("misalign", 32'(misalign), 32'(mon_e.mis));
      end
    end
  end

  task automatic run_txn(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_at, input int exp_req, input logic [31:0] exp_baddr,
                         input logic [3:0] exp_strb, input logic [31:0] exp_bwdata,
                         input logic [31:0] exp_ld, input logic exp_err, input logic exp_mis);
    int cyc, req_cycles, stall_cycles;
    @(negedge clk);
    req_valid = 1'b1;
    mem_write = wr;
    mem_read  = ~wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    check_eq({tag, ".stall_start"}, 32'(stall), 32'd1);
    sb.push_back('{data: exp_ld, err: exp_err, mis: exp_mis});
    @(negedge clk);
    req_valid    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    cyc          = 1;
    req_cycles   = 0;
    stall_cycles = 1;
    while (!ld_valid && cyc < 40) begin
      if (bus_req) begin
        req_cycles++;
        check_eq({tag, ".bus_addr"}, bus_addr, exp_baddr);
        check_eq({tag, ".bus_we"}, 32'(bus_we), 32'(wr));
        if (wr) begin
          check_eq({tag, ".bus_wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
          check_eq({tag, ".bus_wdata"}, bus_wdata, exp_bwdata);
        end
      end
      if (stall) stall_cycles++;
      bus_rdata = rd;
      bus_ack   = bus_req && (ack_at != 0) && (req_cycles == ack_at);
      @(negedge clk);
      bus_ack = 1'b0;
      cyc++;
    end
    check_eq({tag, ".latency"}, 32'(cyc), 32'(exp_req + 1));
    check_eq({tag, ".req_cycles"}, 32'(req_cycles), 32'(exp_req));
    check_eq({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(exp_req + 1));
    check_eq({tag, ".stall_resp"}, 32'(stall), 32'd0);
    check_eq({tag, ".req_resp"}, 32'(bus_req), 32'd0);
    @(negedge clk);
    check_eq({tag, ".pulse_end"}, 32'(ld_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.bus_req", 32'(bus_req), 32'd0);
    check_eq("rst.stall", 32'(stall), 32'd0);
    check_eq("rst.ld_valid", 32'(ld_valid), 32'd0);
    check_eq("rst.bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;

    run_txn("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1,
            32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    run_txn("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 4, 4,
            32'h100, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    run_txn("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 4, 4,
            32'h100, 4'b0000, 32'h0, 32'h00000080, 1'b0, 1'b0);
    run_txn("sb", 1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 2, 2,
            32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0);
    run_txn("sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 1,
            32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
    run_txn("lh", 1'b0, 3'b001, 32'h202, 32'h0, 32'h7FFF_0000, 2, 2,
            32'h200, 4'b0000, 32'h0, 32'h00007FFF, 1'b0, 1'b0);
    run_txn("lh_neg", 1'b0, 3'b001, 32'h200, 32'h0, 32'h1234_8001, 1, 1,
            32'h200, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    run_txn("lhu", 1'b0, 3'b101, 32'h200, 32'h0, 32'h1234_8001, 1, 1,
            32'h200, 4'b0000, 32'h0, 32'h00008001, 1'b0, 1'b0);
    run_txn("lw_f3_111", 1'b0, 3'b111, 32'h304, 32'h0, 32'hA5A5_0F0F, 3, 3,
            32'h304, 4'b0000, 32'h0, 32'hA5A50F0F, 1'b0, 1'b0);
    run_txn("lw_timeout", 1'b0, 3'b010, 32'h400, 32'h0, 32'hFFFF_FFFF, 0, 8,
            32'h400, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
    run_txn("lw_ack8", 1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 8, 8,
            32'h400, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 1, 0,
            32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
`else
    run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 1, 1,
            32'h100, 4'b0000, 32'h0, 32'h11223344, 1'b0, 1'b0);
`endif

    // Reset during the second WAIT cycle abandons the access.
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    mem_read  = 1'b0;
    check_eq("mid_rst.req_w1", 32'(bus_req), 32'd1);
    @(negedge clk);
    check_eq("mid_rst.req_w2", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst.bus_req", 32'(bus_req), 32'd0);
    check_eq("mid_rst.stall", 32'(stall), 32'd0);
    check_eq("mid_rst.flags", {26'd0, ld_valid, bus_err, misalign, bus_we, 2'b00}, 32'd0);
    check_eq("mid_rst.bus_addr", bus_addr, 32'd0);
    check_eq("mid_rst.bus_wdata", bus_wdata, 32'd0);
    check_eq("mid_rst.bus_wstrb", 32'(bus_wstrb), 32'd0);
    check_eq("mid_rst.ld_data", ld_data, 32'd0);
    rst_n = 1'b1;
    run_txn("lw_post_rst", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0BAD_F00D, 1, 1,
            32'h300, 4'b0000, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit of the MEM stage. Consumes the EX-stage ALU result as an effective address, plus rs2 store data and funct3 width. Runs one request/acknowledge transaction on the data-memory bus per load or store. Formats store strobes/data, sign/zero-extends load data, and stalls the pipeline until the access completes.

Parameters:
XLEN, 32, data and address width (fixed at 32 for RV32I)
BUS_TIMEOUT, 255, number of WAIT cycles without bus_ack before the access is aborted with bus_err; minimum 1

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  EX/MEM register holds a valid instruction
mem_read  in  1  instruction is a load
mem_write  in  1  instruction is a store; wins over mem_read if both are set
funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  XLEN  effective address (ALU Result)
wdata  in  XLEN  store data (rs2)
stall  out  1  hold upstream stages
ld_valid  out  1  one-cycle pulse: access complete
ld_data  out  XLEN  extended load data; 0 for stores and errors
bus_err  out  1  qualifies ld_valid: timeout occurred
misalign  out  1  qualifies ld_valid: misaligned access (only with the optional feature)
bus_req  out  1  bus request, registered
bus_we  out  1  1 = write
bus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
bus_wstrb  out  4  byte enables
bus_wdata  out  XLEN  lane-replicated store data
bus_ack  in  1  bus completes the transaction this cycle
bus_rdata  in  XLEN  read word, valid when bus_ack=1

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE. All outputs 0 next cycle. Timeout counter cleared. Applies mid-transaction: bus_req drops at that edge, and the outstanding access is abandoned.
- start = req_valid & (mem_read | mem_write), evaluated in IDLE only.
- IDLE:
  - On start, capture addr, wdata, funct3 and direction.
  - Next state is WAIT, or RESP if misaligned and the trap feature is on.
  - stall = start (combinational) this cycle.
- WAIT:
  - bus_req=1. bus_addr, bus_we, bus_wstrb and bus_wdata stay stable until ack.
  - stall=1. Counter increments each cycle.
  - bus_ack=1: capture bus_rdata, go to RESP, bus_req=0 next cycle.
  - Counter reaches BUS_TIMEOUT with no ack: go to RESP with bus_err=1.
  - Ack on the same cycle as the timeout: ack wins, no error.
- RESP:
  - ld_valid=1, stall=0 for exactly one cycle, then IDLE.
  - bus_ack in RESP or IDLE is ignored.
  - No new request is accepted in RESP; the next instruction is sampled in the following IDLE cycle.
- Minimum latency: 3 cycles from start to ld_valid (ack on first WAIT cycle); stall is high for 2 cycles.
- Store formatting, off=addr[1:0]:
  - B: wstrb=0001<<off, wdata byte replicated 4x.
  - H: wstrb=0011<<off, halfword replicated 2x.
  - W: wstrb=1111.
- Load extraction:
  - B/BU: byte at lane off; B sign-extends, BU zero-extends.
  - H/HU: halfword at lane off[1]; H sign-extends, HU zero-extends.
  - W: full word.
- Unlisted funct3 (011/110/111) is treated as W.
- Misaligned means: H/HU/SH with addr[0]=1, or W with addr[1:0]!=0.

Optional Feature:
MEM_LSU_MISALIGN_TRAP_EN
- Defined: a misaligned access issues no bus transaction. IDLE goes to RESP; ld_valid=1, misalign=1, ld_data=0.
- Undefined: misalign is tied 0. Offset bits are forced to alignment (H uses off&2'b10, W uses 0) and the access proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (IDLE, WAIT, RESP, 2 bits)
  - timeout counter width derived from BUS_TIMEOUT
- One combinational sub-module, lsu_align: store strobe/data replication, load lane select and extension, and misalign detect. The FSM and bus registers stay in mem_lsu.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack on 1st WAIT cycle -> bus_addr=0x100, wstrb=1111, bus_wdata=0xDEADBEEF; ld_valid 3 cycles after start; stall high 2 cycles.
- LB addr=0x103, bus_rdata=0x80FF_0000, ack after 4 WAIT cycles -> ld_data=0xFFFFFF80; LBU at the same address -> 0x00000080; bus_req held 4 cycles.
- SH addr=0x202, wdata=0x1234ABCD -> wstrb=1100, bus_wdata=0xABCDABCD; LH addr=0x202 with rdata=0x7FFF0000 -> 0x00007FFF.
- No ack, BUS_TIMEOUT=8 -> bus_req high 8 cycles, then ld_valid=1, bus_err=1, ld_data=0; a second case with ack on the 8th cycle gives bus_err=0.
- LW addr=0x101: with MEM_LSU_MISALIGN_TRAP_EN -> no bus_req, ld_valid+misalign 1 cycle after start; without it -> bus_addr=0x100, normal completion.
- rst_n=0 on the 2nd WAIT cycle -> bus_req=0, stall=0, all outputs 0 next cycle; a new LW after reset completes normally.
